// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, pattern mode encoding and the
// per-frame control bundle shared by the pattern generator files.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int OFF_W  = 10;
    localparam int FCNT_W = 8;

    typedef enum logic [1:0] {
        MODE_STRIPES  = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_PULSE    = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e      mode;
        logic [1:0] dir;
        logic [2:0] speed;
        logic       pause;
    } ctrl_t;

    function automatic int span(
        input int a,
        input int b,
        input int c,
        input int d
    );
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running pixel/line counters plus sync, active
// and frame-boundary decode.
// Ports: clk, rst_n in; hpos, vpos counters; hs_act/vs_act sync
// windows (polarity-free); active visible area; boundary = last
// pixel of frame; origin = pixel (0,0).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hs_act,
    output logic          vs_act,
    output logic          active,
    output logic          boundary,
    output logic          origin
);

    localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic h_last;
    logic v_last;

    assign h_last = (hpos == H_LAST);
    assign v_last = (vpos == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos <= '0;
            vpos <= '0;
        end else if (h_last) begin
            hpos <= '0;
            vpos <= v_last ? '0 : vpos + VW'(1);
        end else begin
            hpos <= hpos + HW'(1);
        end
    end

    assign hs_act   = (hpos >= HS_BEG) && (hpos <= HS_END);
    assign vs_act   = (vpos >= VS_BEG) && (vpos <= VS_END);
    assign active   = (hpos < H_VIS) && (vpos < V_VIS);
    assign boundary = h_last && v_last;
    assign origin   = (hpos == '0) && (vpos == '0);

endmodule

// File: rtl/vga_scroll_pattern_gen.sv
// vga_scroll_pattern_gen: VGA timing with a scrolling test pattern
// (stripes, checker, gradient, frame-count pulse).
// Ports: clk, rst_n; mode/dir/speed/pause controls, latched once per
// frame; hsync/vsync at SYNC_POL; red/green/blue; video_active;
// frame_tick on the output cycle of pixel (0,0).
module vga_scroll_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   COLOR_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [1:0]            dir,
    input  logic [2:0]            speed,
    input  logic                  pause,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  video_active,
    output logic                  frame_tick
);

    localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          hs_act;
    logic          vs_act;
    logic          active;
    logic          boundary;
    logic          origin;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .hpos     (hpos),
        .vpos     (vpos),
        .hs_act   (hs_act),
        .vs_act   (vs_act),
        .active   (active),
        .boundary (boundary),
        .origin   (origin)
    );

    ctrl_t             sh;
    ctrl_t             ctrl_in;
    mode_e             cur_mode;
    logic              restart;
    logic [OFF_W-1:0]  x_off;
    logic [OFF_W-1:0]  y_off;
    logic [FCNT_W-1:0] frame_cnt;
    logic [OFF_W-1:0]  step;

    assign ctrl_in = '{
        mode:  mode_e'(mode),
        dir:   dir,
        speed: speed,
        pause: pause
    };

    assign step = OFF_W'(sh.speed);

    // The frame that starts right after reset has no preceding
    // boundary, so its controls come from the inputs on that first
    // cycle (restart) instead of from the cleared shadow.
    assign cur_mode = restart ? ctrl_in.mode : sh.mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh        <= '0;
            restart   <= 1'b1;
            x_off     <= '0;
            y_off     <= '0;
            frame_cnt <= '0;
        end else begin
            restart <= 1'b0;
            // Update reads sh before the capture below lands, so it
            // always applies the outgoing frame's controls.
            if (boundary) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
                if (!sh.pause) begin
                    x_off <= sh.dir[0] ? x_off - step : x_off + step;
                    if (sh.dir[1]) begin
                        y_off <= y_off + step;
                    end
                end
            end
            if (boundary || restart) begin
                sh <= ctrl_in;
            end
        end
    end

    logic [OFF_W-1:0] mx;
    logic [OFF_W-1:0] my;
    logic [OFF_W-1:0] mxy;

    assign mx  = OFF_W'(hpos) + x_off;
    assign my  = OFF_W'(vpos) + y_off;
    assign mxy = mx ^ my;

    logic unused_bits;
    assign unused_bits = ^{mx, my, mxy};

    logic [COLOR_BITS-1:0] pat_r;
    logic [COLOR_BITS-1:0] pat_g;
    logic [COLOR_BITS-1:0] pat_b;

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        unique case (1'b1)
            (cur_mode == MODE_STRIPES): begin
                pat_r = {COLOR_BITS{mx[5]}};
                pat_g = {COLOR_BITS{mx[5]}};
                pat_b = {COLOR_BITS{mx[5]}};
            end
            (cur_mode == MODE_CHECKER): begin
                pat_r = {COLOR_BITS{mx[5] ^ my[5]}};
                pat_g = {COLOR_BITS{mx[5] ^ my[5]}};
                pat_b = {COLOR_BITS{mx[5] ^ my[5]}};
            end
            (cur_mode == MODE_GRADIENT): begin
                pat_r = mx[9 -: COLOR_BITS];
                pat_g = my[8 -: COLOR_BITS];
                pat_b = mxy[7 -: COLOR_BITS];
            end
            (cur_mode == MODE_PULSE): begin
                pat_r = frame_cnt[7 -: COLOR_BITS];
                pat_g = frame_cnt[7 -: COLOR_BITS];
                pat_b = frame_cnt[7 -: COLOR_BITS];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
            video_active <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            hsync        <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync        <= vs_act ? SYNC_POL : ~SYNC_POL;
            red          <= active ? pat_r : '0;
            green        <= active ? pat_g : '0;
            blue         <= active ? pat_b : '0;
            video_active <= active;
            // Origin straight out of reset is a restart, not a new
            // frame, so it does not tick.
            frame_tick   <= origin && !restart;
        end
    end

endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// tb_vga_scroll_pattern_gen: directed checks of timing, scrolling,
// pattern modes, pause and reset on a reduced 100x40 raster.
module tb_vga_scroll_pattern_gen;

    localparam int HA = 80;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 8;
    localparam int VA = 36;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = 100;
    localparam int VT = 40;
    localparam int FT = 4000;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [1:0]    dir = 2'd0;
    logic [2:0]    speed = 3'd0;
    logic          pause = 1'b0;
    logic          hsync;
    logic          vsync;
    logic [CB-1:0] red;
    logic [CB-1:0] green;
    logic [CB-1:0] blue;
    logic          video_active;
    logic          frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_scroll_pattern_gen #(
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HS),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .SYNC_POL   (1'b0),
        .COLOR_BITS (CB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .dir          (dir),
        .speed        (speed),
        .pause        (pause),
        .hsync        (hsync),
        .vsync        (vsync),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .video_active (video_active),
        .frame_tick   (frame_tick)
    );

    // After step() the outputs carry pixel index cyc-1 since release.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_pix(input int f, input int v, input int h);
        int target;
        target = f * FT + v * HT + h + 1;
        while (cyc < target) step();
    endtask

    task automatic apply_reset(
        input logic [1:0] m,
        input logic [1:0] d,
        input logic [2:0] s,
        input logic       p
    );
        @(negedge clk);
        rst_n = 1'b0;
        mode = m;
        dir = d;
        speed = s;
        pause = p;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'd3;
        dir = 2'd3;
        speed = 3'd7;
        pause = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_sync got %b%b want 11", hsync, vsync);
        end
        n_cmp++;
        if ({red, green, blue} !== '0) begin
            n_bad++;
            $display("FAIL rst_rgb got %h want 0", {red, green, blue});
        end
        n_cmp++;
        if (video_active !== 1'b0 || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_va_tick got %b%b want 00",
                     video_active, frame_tick);
        end
        n_cmp++;
        if (dut.x_off !== 10'd0 || dut.frame_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_state got x=%0d fc=%0d want 0 0",
                     dut.x_off, dut.frame_cnt);
        end
    endtask

    task automatic test_timing();
        int hs_first;
        int hs_cnt;
        int vs_first;
        int vs_cnt;
        int va_cnt;
        int tk_cnt;
        int p;
        hs_first = -1;
        vs_first = -1;
        hs_cnt = 0;
        vs_cnt = 0;
        va_cnt = 0;
        tk_cnt = 0;
        apply_reset(2'd0, 2'd0, 3'd0, 1'b0);
        for (int n = 1; n <= FT; n++) begin
            step();
            p = n - 1;
            if (p < HT && !hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = p;
            end
            if (!vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = p;
            end
            if (video_active) va_cnt++;
            if (frame_tick) tk_cnt++;
            if (p == 0) begin
                n_cmp++;
                if (video_active !== 1'b1 || red !== 2'd0) begin
                    n_bad++;
                    $display("FAIL first_pix got va=%b r=%0d want 1 0",
                             video_active, red);
                end
            end
            if (p == 31) begin
                n_cmp++;
                if (red !== 2'd0) begin
                    n_bad++;
                    $display("FAIL stripe31 got %0d want 0", red);
                end
            end
            if (p == 32) begin
                n_cmp++;
                if ({red, green, blue} !== 6'h3f) begin
                    n_bad++;
                    $display("FAIL stripe32 got %h want 3f",
                             {red, green, blue});
                end
            end
            if (p == 96) begin
                n_cmp++;
                if (red !== 2'd0 || video_active !== 1'b0) begin
                    n_bad++;
                    $display("FAIL blank96 got r=%0d va=%b want 0 0",
                             red, video_active);
                end
            end
        end
        n_cmp++;
        if (hs_first !== 84 || hs_cnt !== 8) begin
            n_bad++;
            $display("FAIL hsync got start=%0d len=%0d want 84 8",
                     hs_first, hs_cnt);
        end
        n_cmp++;
        if (vs_first !== 3700 || vs_cnt !== 200) begin
            n_bad++;
            $display("FAIL vsync got start=%0d len=%0d want 3700 200",
                     vs_first, vs_cnt);
        end
        n_cmp++;
        if (va_cnt !== 2880) begin
            n_bad++;
            $display("FAIL va_count got %0d want 2880", va_cnt);
        end
        n_cmp++;
        if (tk_cnt !== 0) begin
            n_bad++;
            $display("FAIL tick_after_reset got %0d want 0", tk_cnt);
        end
        step();
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL tick_f1 got %b want 1", frame_tick);
        end
        tk_cnt = 0;
        for (int n = FT + 2; n <= 2 * FT; n++) begin
            step();
            if (frame_tick) tk_cnt++;
        end
        step();
        n_cmp++;
        if (tk_cnt !== 0 || frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL period got mid=%0d tick=%b want 0 1",
                     tk_cnt, frame_tick);
        end
    endtask

    task automatic test_scroll_inc();
        apply_reset(2'd0, 2'b00, 3'd3, 1'b0);
        goto_pix(0, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd3) begin
            n_bad++;
            $display("FAIL inc_b1 got %0d want 3", dut.x_off);
        end
        goto_pix(1, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd6 || dut.y_off !== 10'd0) begin
            n_bad++;
            $display("FAIL inc_b2 got x=%0d y=%0d want 6 0",
                     dut.x_off, dut.y_off);
        end
        goto_pix(2, 0, 0);
        n_cmp++;
        if (red !== 2'd0 || dut.frame_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL inc_pix0 got r=%0d fc=%0d want 0 2",
                     red, dut.frame_cnt);
        end
        goto_pix(2, 0, 26);
        n_cmp++;
        if (red !== 2'd3) begin
            n_bad++;
            $display("FAIL inc_pix26 got %0d want 3", red);
        end
    endtask

    task automatic test_scroll_dec();
        apply_reset(2'd2, 2'b01, 3'd1, 1'b0);
        goto_pix(0, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd1023 || dut.y_off !== 10'd0) begin
            n_bad++;
            $display("FAIL dec_b1 got x=%0d y=%0d want 1023 0",
                     dut.x_off, dut.y_off);
        end
        goto_pix(1, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 6'b11_00_11) begin
            n_bad++;
            $display("FAIL grad_h0 got %b want 110011",
                     {red, green, blue});
        end
        goto_pix(1, 0, 1);
        n_cmp++;
        if ({red, green, blue} !== 6'b00_00_00) begin
            n_bad++;
            $display("FAIL grad_h1 got %b want 000000",
                     {red, green, blue});
        end
        goto_pix(1, 35, 65);
        n_cmp++;
        if ({red, green, blue} !== 6'b00_00_01) begin
            n_bad++;
            $display("FAIL grad_v35 got %b want 000001",
                     {red, green, blue});
        end
    endtask

    task automatic test_mode_change();
        apply_reset(2'd0, 2'b00, 3'd0, 1'b0);
        goto_pix(0, 20, 0);
        mode = 2'd1;
        goto_pix(0, 33, 0);
        n_cmp++;
        if (red !== 2'd0) begin
            n_bad++;
            $display("FAIL mc_f0_h0 got %0d want 0", red);
        end
        goto_pix(0, 33, 32);
        n_cmp++;
        if (red !== 2'd3) begin
            n_bad++;
            $display("FAIL mc_f0_h32 got %0d want 3", red);
        end
        goto_pix(1, 33, 0);
        n_cmp++;
        if (red !== 2'd3) begin
            n_bad++;
            $display("FAIL mc_f1_h0 got %0d want 3", red);
        end
        goto_pix(1, 33, 32);
        n_cmp++;
        if (red !== 2'd0) begin
            n_bad++;
            $display("FAIL mc_f1_h32 got %0d want 0", red);
        end
        mode = 2'd3;
        goto_pix(2, 0, 0);
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL mc_tick got %b want 1", frame_tick);
        end
        goto_pix(2, 0, 32);
        n_cmp++;
        if (red !== 2'd0) begin
            n_bad++;
            $display("FAIL pulse_h32 got %0d want 0", red);
        end
    endtask

    task automatic test_pause();
        apply_reset(2'd0, 2'b11, 3'd2, 1'b0);
        goto_pix(0, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd1022 || dut.y_off !== 10'd2) begin
            n_bad++;
            $display("FAIL pz_b1 got x=%0d y=%0d want 1022 2",
                     dut.x_off, dut.y_off);
        end
        goto_pix(1, 10, 0);
        pause = 1'b1;
        goto_pix(1, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd1020 || dut.y_off !== 10'd4 ||
            dut.frame_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL pz_b2 got x=%0d y=%0d fc=%0d want 1020 4 2",
                     dut.x_off, dut.y_off, dut.frame_cnt);
        end
        goto_pix(2, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd1020 || dut.y_off !== 10'd4) begin
            n_bad++;
            $display("FAIL pz_b3 got x=%0d y=%0d want 1020 4",
                     dut.x_off, dut.y_off);
        end
        goto_pix(4, 10, 0);
        pause = 1'b0;
        goto_pix(4, VT - 1, HT - 1);
        n_cmp++;
        if (dut.x_off !== 10'd1020 || dut.y_off !== 10'd4 ||
            dut.frame_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL pz_b5 got x=%0d y=%0d fc=%0d want 1020 4 5",
                     dut.x_off, dut.y_off, dut.frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(2'd0, 2'b10, 3'd3, 1'b0);
        goto_pix(1, 20, 32);
        n_cmp++;
        if (red !== 2'd3 || dut.y_off !== 10'd3) begin
            n_bad++;
            $display("FAIL mid_pre got r=%0d y=%0d want 3 3",
                     red, dut.y_off);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({red, green, blue} !== '0 || video_active !== 1'b0 ||
            hsync !== 1'b1 || vsync !== 1'b1 || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_out got rgb=%h va=%b hs=%b vs=%b",
                     {red, green, blue}, video_active, hsync, vsync);
        end
        n_cmp++;
        if (dut.y_off !== 10'd0 || dut.frame_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_rst_state got y=%0d fc=%0d want 0 0",
                     dut.y_off, dut.frame_cnt);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (video_active !== 1'b0 || red !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_rst_hold got va=%b r=%0d want 0 0",
                     video_active, red);
        end
        mode = 2'd0;
        dir = 2'd0;
        speed = 3'd0;
        pause = 1'b0;
        rst_n = 1'b1;
        cyc = 0;
        step();
        n_cmp++;
        if (frame_tick !== 1'b0 || video_active !== 1'b1 ||
            red !== 2'd0 || dut.x_off !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_restart got tk=%b va=%b r=%0d x=%0d",
                     frame_tick, video_active, red, dut.x_off);
        end
        goto_pix(0, 0, 32);
        n_cmp++;
        if (red !== 2'd3) begin
            n_bad++;
            $display("FAIL mid_h32 got %0d want 3", red);
        end
        goto_pix(1, 0, 0);
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_tick got %b want 1", frame_tick);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_scroll_inc();
        test_scroll_dec();
        test_mode_change();
        test_pause();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scroll_pattern_gen.md
VGA_SCROLL_PATTERN_GEN -- requirements
Module: vga_scroll_pattern_gen

Interface
REQ-001 The block SHALL have exactly these parameters (name, default, meaning):
  H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch.
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
  SYNC_POL 0 sync active level (0 = active-low); COLOR_BITS 2 bits per channel, legal 1..4.
REQ-002 The block SHALL have exactly these ports (name, direction, width, meaning):
  clk  in  1  pixel clock
  rst_n  in  1  reset, asynchronous, active-low
  mode  in  2  pattern select: 0 stripes, 1 checker, 2 gradient, 3 pulse
  dir  in  2  bit0 = x direction (0 increment, 1 decrement); bit1 = vertical scroll enable (y increments)
  speed  in  3  offset step per frame, 0..7
  pause  in  1  hold scroll offsets
  hsync, vsync  out  1  sync outputs at SYNC_POL
  red, green, blue  out  COLOR_BITS  colour outputs
  video_active  out  1  high for visible pixels
  frame_tick  out  1  one-cycle pulse marking pixel (0,0)

Function
REQ-003 hpos SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_*), then wrap to 0; vpos SHALL advance on hpos wrap and count 0..V_TOTAL-1, then wrap.
REQ-004 hsync SHALL be active for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync SHALL be active for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-005 Active region SHALL be hpos<H_ACTIVE and vpos<V_ACTIVE.
REQ-006 All outputs SHALL be registered with exactly 1 clk latency from counter state, mutually aligned.
REQ-007 mode, dir, speed and pause SHALL be sampled into shadow registers only on the frame-boundary cycle (hpos=H_TOTAL-1, vpos=V_TOTAL-1); mid-frame changes SHALL take effect from the next frame only.
REQ-008 On each frame boundary with shadow pause=0: x_off (10-bit) SHALL become x_off+speed (dir0=0) or x_off-speed (dir0=1), mod 1024; y_off (10-bit) SHALL become y_off+speed if dir1=1, else hold. If pause=1, both SHALL hold.
REQ-009 Offset update and shadow capture in the same boundary cycle SHALL use the previous frame's shadow values for the update.
REQ-010 frame_cnt (8-bit) SHALL increment at every frame boundary regardless of pause, wrapping 255->0.
REQ-011 mx = (hpos+x_off) mod 1024, my = (vpos+y_off) mod 1024.
REQ-012 Mode 0: all channels = COLOR_BITS copies of mx[5].
REQ-013 Mode 1: all channels = COLOR_BITS copies of mx[5]^my[5].
REQ-014 Mode 2: red = mx[9 -: COLOR_BITS], green = my[8 -: COLOR_BITS], blue = (mx^my)[7 -: COLOR_BITS].
REQ-015 Mode 3: all channels = frame_cnt[7 -: COLOR_BITS].
REQ-016 Outside the active region, colours SHALL be 0 and video_active 0.
REQ-017 frame_tick SHALL be high for exactly the output cycle carrying pixel (0,0).

Reset
REQ-018 While rst_n=0: hpos, vpos, x_off, y_off and frame_cnt SHALL be 0; shadow registers SHALL be mode 0, dir 0, speed 0, pause 0; syncs inactive (!SYNC_POL); colours 0; video_active 0; frame_tick 0.
REQ-019 Reset asserted mid-frame SHALL take effect immediately; after release, the first output cycle SHALL be pixel (0,0) with frame_tick=0.

Structure
REQ-020 Default timing constants and the mode encoding SHALL live in shared package vga_pkg.
REQ-021 Counters and sync decode SHALL be in sub-module vga_timing; pattern, scroll and output registers SHALL be in the top.

Verification
REQ-022 Defaults, SYNC_POL=0: hsync low for exactly 96 clocks per 800-clock line starting 656 clocks after line start; vsync low for 2 lines; frame period 420000 clocks.
REQ-023 speed=3, dir=0, pause=0 held from reset: x_off=6 after the second frame boundary; y_off=0.
REQ-024 speed=1, dir=2'b01 from reset: x_off=1023 after the first boundary; dir=2'b10: y_off increments by 1 per frame.
REQ-025 mode changed 0->1 at line 100: frame remains stripes to its end; checker begins at next pixel (0,0).
REQ-026 pause=1 for 3 frames: x_off and y_off constant; frame_cnt advances by 3.
REQ-027 rst_n pulsed at line 240: all outputs at reset values during reset; after release, frame restarts at (0,0) and offsets are 0.
